lbp_scan_ctrl: RTL and testbench
================================

LBP_SCAN_CTRL -- requirements
Module: lbp_scan_ctrl

Interface
REQ-001 Parameter IMG_W, 128, image width in pixels.
REQ-002 Parameter IMG_H, 128, image height in pixels.
REQ-003 Parameter ADDR_W, 14, pixel address width (log2(IMG_W*IMG_H)).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 gray_ready  input  1  gray memory available; scan may start or continue.
REQ-007 gray_req  output  1  read request to gray memory.
REQ-008 gray_addr  output  ADDR_W  read address, row*IMG_W+col.
REQ-009 gray_data  input  8  read data, valid at the rising edge ending a gray_req cycle.
REQ-010 win_start  output  1  one-cycle pulse: win_data holds a complete 3x3 window.
REQ-011 win_data  output  72  window; pixel k (0..8, row-major, k=4 centre) in bits [8k+7:8k].
REQ-012 core_done  input  1  LBP core result valid.
REQ-013 core_lbp  input  8  LBP code for current window.
REQ-014 lbp_valid  output  1  one-cycle write strobe to result memory.
REQ-015 lbp_addr  output  ADDR_W  result address of window centre.
REQ-016 lbp_data  output  8  registered core_lbp.
REQ-017 finish  output  1  whole image processed; held high until reset.

Function
REQ-018 States: IDLE, FILL, SHIFT, CALC, WRITE, DONE.
REQ-019 IDLE -> FILL when gray_ready=1; centre counters at (row=1, col=1).
REQ-020 Only interior centres row 1..IMG_H-2, col 1..IMG_W-2 are processed, row-major; border addresses are never written.
REQ-021 FILL: 9 consecutive gray_req cycles, column-major over cols c-1..c+1, rows r-1..r+1; -> CALC after 9th capture.
REQ-022 SHIFT: window shifts left one column; 3 gray_req cycles read col c+1, rows r-1..r+1; -> CALC.
REQ-023 gray_req is high only in FILL/SHIFT fetch cycles; gray_data captured into the addressed window slot at the edge ending that cycle.
REQ-024 gray_ready=0 in FILL/SHIFT: gray_req=0, fetch counter and address held; resume on gray_ready=1, no read lost or duplicated.
REQ-025 CALC: win_start=1 in first CALC cycle only; wait for core_done; core_done outside CALC or in the win_start cycle is ignored.
REQ-026 On core_done in CALC: lbp_data<=core_lbp, lbp_addr<=r*IMG_W+c; -> WRITE.
REQ-027 WRITE: lbp_valid=1 for exactly one cycle; then col<IMG_W-2 -> col+1, SHIFT; col=IMG_W-2, row<IMG_H-2 -> col=1, row+1, FILL; last centre -> DONE.
REQ-028 DONE: finish=1, gray_req=0, lbp_valid=0; remain until reset.
REQ-029 Address arithmetic in ADDR_W bits, no wrap for legal parameters; exactly (IMG_W-2)*(IMG_H-2) writes (15876 at default).
REQ-030 lbp_valid and gray_req never high in the same cycle.

Reset
REQ-031 reset=0 asynchronously forces IDLE, counters to (1,1), and gray_req, gray_addr, win_start, win_data, lbp_valid, lbp_addr, lbp_data, finish to 0.
REQ-032 Reset mid-scan discards the partial window; the next scan restarts from centre (1,1) with FILL.

Structure
REQ-033 Package lbp_pkg holds IMG_W, IMG_H, ADDR_W defaults and the state enum typedef.
REQ-034 Sub-module lbp_win_reg: 3x3 8-bit window register with load-slot and shift-left-column operations, driving win_data.

Verification
REQ-035 Reset then gray_ready=1, core returns core_done 1 cycle after win_start -> first 9 gray_addr = 0,128,256,1,129,257,2,130,258; first lbp_valid with lbp_addr=129 within 13 cycles.
REQ-036 Full 128x128 image, core model echoes centre pixel -> 15876 writes, each lbp_data equals gray[lbp_addr], no border address written, finish high after last write at lbp_addr=16254.
REQ-037 Row end: after write at lbp_addr=254 -> FILL with gray_addr sequence 128,256,384,... and next write at lbp_addr=257.
REQ-038 gray_ready dropped 3 cycles in FILL -> gray_req=0 for those cycles, address held, window contents identical to uninterrupted run.
REQ-039 core_done delayed 5 cycles, spurious core_done in SHIFT -> spurious pulse ignored, single lbp_valid per centre.
REQ-040 reset asserted mid-row (lbp_addr=300 pending) -> all outputs 0 immediately; after release, scan restarts with gray_addr=0 and first write at 129.

Source files
------------

// File: rtl/lbp_pkg.sv
// lbp_pkg: shared defaults, FSM state type and window-slot helper for the
// LBP scan controller.
//   IMG_W_DEF / IMG_H_DEF : default image size in pixels
//   ADDR_W_DEF            : default pixel address width
//   lbp_state_e           : scan controller FSM states
//   slot_idx()            : row-major window slot for a (row, col) window offset
package lbp_pkg;

    localparam int unsigned IMG_W_DEF  = 128;
    localparam int unsigned IMG_H_DEF  = 128;
    localparam int unsigned ADDR_W_DEF = 14;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StShift,
        StCalc,
        StWrite,
        StDone
    } lbp_state_e;

    function automatic logic [3:0] slot_idx(logic [1:0] row_off, logic [1:0] col_off);
        return {2'b00, row_off} * 4'd3 + {2'b00, col_off};
    endfunction

endpackage

// File: rtl/lbp_win_reg.sv
// lbp_win_reg: 3x3 window of 8-bit pixels.
//   clk_i, rst_ni : clock, asynchronous active-low reset (clears window)
//   load_i        : write data_i into slot slot_i (0..8, row-major)
//   slot_i        : target slot for load_i
//   data_i        : pixel to load
//   shift_i       : shift every row left by one column; column 2 keeps its old
//                   value until reloaded
//   win_o         : window, slot k in bits [8k+7:8k]
module lbp_win_reg (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic [3:0]  slot_i,
    input  logic [7:0]  data_i,
    input  logic        shift_i,
    output logic [71:0] win_o
);

    logic [8:0][7:0] win_q, win_d;

    always_comb begin
        win_d = win_q;
        if (shift_i) begin
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[3] = win_q[4];
            win_d[4] = win_q[5];
            win_d[6] = win_q[7];
            win_d[7] = win_q[8];
        end
        if (load_i) begin
            win_d[slot_i] = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            win_q <= '0;
        end else begin
            win_q <= win_d;
        end
    end

    assign win_o = win_q;

endmodule

// File: rtl/lbp_scan_ctrl.sv
// lbp_scan_ctrl: raster-scans the interior pixels of a gray image, builds the
// 3x3 neighbourhood of each centre, hands it to an external LBP core and writes
// the returned code to result memory at the centre address.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   gray_ready_i           : gray memory available; stalls fetches when low
//   gray_req_o/gray_addr_o : gray memory read request / address (row*IMG_W+col)
//   gray_data_i            : read data, sampled at the edge ending a request cycle
//   win_start_o/win_data_o : one-cycle "window valid" pulse / 3x3 window
//   core_done_i/core_lbp_i : LBP core result strobe / code
//   lbp_valid_o/lbp_addr_o/lbp_data_o : result memory write strobe / address / data
//   finish_o               : whole image processed, held until reset
module lbp_scan_ctrl
    import lbp_pkg::*;
#(
    parameter int unsigned IMG_W  = IMG_W_DEF,
    parameter int unsigned IMG_H  = IMG_H_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              gray_ready_i,
    output logic              gray_req_o,
    output logic [ADDR_W-1:0] gray_addr_o,
    input  logic [7:0]        gray_data_i,
    output logic              win_start_o,
    output logic [71:0]       win_data_o,
    input  logic              core_done_i,
    input  logic [7:0]        core_lbp_i,
    output logic              lbp_valid_o,
    output logic [ADDR_W-1:0] lbp_addr_o,
    output logic [7:0]        lbp_data_o,
    output logic              finish_o
);

    localparam logic [ADDR_W-1:0] LastCol = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] LastRow = ADDR_W'(IMG_H - 2);
    localparam logic [ADDR_W-1:0] One     = ADDR_W'(1);

    lbp_state_e        state_q, state_d;
    logic [ADDR_W-1:0] row_q, row_d, col_q, col_d;
    // Fetch offsets within the window: fr = row offset, fc = column offset.
    logic [1:0]        fr_q, fr_d, fc_q, fc_d;
    logic              first_q, first_d;
    logic [ADDR_W-1:0] lbp_addr_q, lbp_addr_d;
    logic [7:0]        lbp_data_q, lbp_data_d;

    logic [ADDR_W-1:0] fetch_row, fetch_col, fetch_addr, centre_addr;
    logic              win_load, win_shift;

    assign fetch_row   = row_q + ADDR_W'(fr_q) - One;
    assign fetch_col   = col_q + ADDR_W'(fc_q) - One;
    assign fetch_addr  = fetch_row * ADDR_W'(IMG_W) + fetch_col;
    assign centre_addr = row_q * ADDR_W'(IMG_W) + col_q;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            row_q      <= One;
            col_q      <= One;
            fr_q       <= '0;
            fc_q       <= '0;
            first_q    <= 1'b0;
            lbp_addr_q <= '0;
            lbp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            fr_q       <= fr_d;
            fc_q       <= fc_d;
            first_q    <= first_d;
            lbp_addr_q <= lbp_addr_d;
            lbp_data_q <= lbp_data_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        fr_d       = fr_q;
        fc_d       = fc_q;
        first_d    = 1'b0;
        lbp_addr_d = lbp_addr_q;
        lbp_data_d = lbp_data_q;
        case (state_q)
            StIdle: begin
                if (gray_ready_i) begin
                    state_d = StFill;
                    row_d   = One;
                    col_d   = One;
                    fr_d    = '0;
                    fc_d    = '0;
                end
            end
            StFill: begin
                // Column-major: walk rows within a column, then next column.
                if (gray_ready_i) begin
                    if (fr_q == 2'd2) begin
                        fr_d = '0;
                        if (fc_q == 2'd2) begin
                            state_d = StCalc;
                            first_d = 1'b1;
                        end else begin
                            fc_d = fc_q + 2'd1;
                        end
                    end else begin
                        fr_d = fr_q + 2'd1;
                    end
                end
            end
            StShift: begin
                if (gray_ready_i) begin
                    if (fr_q == 2'd2) begin
                        fr_d    = '0;
                        state_d = StCalc;
                        first_d = 1'b1;
                    end else begin
                        fr_d = fr_q + 2'd1;
                    end
                end
            end
            StCalc: begin
                // A done strobe coinciding with win_start belongs to a stale window.
                if (core_done_i && !first_q) begin
                    lbp_data_d = core_lbp_i;
                    lbp_addr_d = centre_addr;
                    state_d    = StWrite;
                end
            end
            StWrite: begin
                fr_d = '0;
                if (col_q < LastCol) begin
                    col_d   = col_q + One;
                    fc_d    = 2'd2;
                    state_d = StShift;
                end else if (row_q < LastRow) begin
                    col_d   = One;
                    row_d   = row_q + One;
                    fc_d    = '0;
                    state_d = StFill;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs
    always_comb begin
        gray_req_o  = 1'b0;
        gray_addr_o = '0;
        win_load    = 1'b0;
        win_shift   = 1'b0;
        win_start_o = 1'b0;
        lbp_valid_o = 1'b0;
        finish_o    = 1'b0;
        if (state_q == StFill || state_q == StShift) begin
            gray_req_o  = gray_ready_i;
            gray_addr_o = fetch_addr;
            win_load    = gray_ready_i;
        end
        if (state_q == StCalc) begin
            win_start_o = first_q;
        end
        if (state_q == StWrite) begin
            lbp_valid_o = 1'b1;
            win_shift   = (state_d == StShift);
        end
        if (state_q == StDone) begin
            finish_o = 1'b1;
        end
    end

    assign lbp_addr_o = lbp_addr_q;
    assign lbp_data_o = lbp_data_q;

    lbp_win_reg u_win_reg (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (win_load),
        .slot_i  (slot_idx(fr_q, fc_q)),
        .data_i  (gray_data_i),
        .shift_i (win_shift),
        .win_o   (win_data_o)
    );

endmodule

// File: tb/tb_lbp_scan_ctrl.sv
// Bench for lbp_scan_ctrl on a 128x6 image: gray memory and an LBP core that
// echoes the window centre are modelled here; expected fetch and write
// addresses are queued per scan and popped as the DUT produces them.
module tb_lbp_scan_ctrl;

    localparam int W    = 128;
    localparam int H    = 6;
    localparam int AW   = 10;
    localparam int LAST = (H - 2) * W + W - 2;
    localparam int NWR  = (W - 2) * (H - 2);

    logic          clk;
    logic          rst_ni;
    logic          gray_ready;
    logic          gray_req;
    logic [AW-1:0] gray_addr;
    logic [7:0]    gray_data;
    logic          win_start;
    logic [71:0]   win_data;
    logic          core_done;
    logic [7:0]    core_lbp;
    logic          lbp_valid;
    logic [AW-1:0] lbp_addr;
    logic [7:0]    lbp_data;
    logic          finish;

    int n_vec = 0;
    int n_err = 0;
    int exp_fetch[$];
    int exp_wr[$];
    int core_delay;
    bit spur_en;
    int cyc    = 0;
    int ws_cyc = 0;
    int wr_cnt = 0;

    lbp_scan_ctrl #(
        .IMG_W  (W),
        .IMG_H  (H),
        .ADDR_W (AW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .gray_ready_i (gray_ready),
        .gray_req_o   (gray_req),
        .gray_addr_o  (gray_addr),
        .gray_data_i  (gray_data),
        .win_start_o  (win_start),
        .win_data_o   (win_data),
        .core_done_i  (core_done),
        .core_lbp_i   (core_lbp),
        .lbp_valid_o  (lbp_valid),
        .lbp_addr_o   (lbp_addr),
        .lbp_data_o   (lbp_data),
        .finish_o     (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pix(int a);
        int v;
        v = a * 37 + (a / 128) * 11 + 5;
        return v[7:0];
    endfunction

    assign gray_data = pix(int'(gray_addr));

    function automatic logic [71:0] exp_win(int ca);
        logic [71:0] w;
        int r, c;
        r = ca / W;
        c = ca % W;
        for (int kr = 0; kr < 3; kr++) begin
            for (int kc = 0; kc < 3; kc++) begin
                w[(kr * 3 + kc) * 8 +: 8] = pix((r - 1 + kr) * W + c - 1 + kc);
            end
        end
        return w;
    endfunction

    task automatic check_eq(string tag, logic [127:0] obs, logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push_scan();
        for (int r = 1; r <= H - 2; r++) begin
            for (int c = 1; c <= W - 2; c++) begin
                if (c == 1) begin
                    for (int co = 0; co < 3; co++) begin
                        for (int ro = 0; ro < 3; ro++) begin
                            exp_fetch.push_back((r - 1 + ro) * W + c - 1 + co);
                        end
                    end
                end else begin
                    for (int ro = 0; ro < 3; ro++) begin
                        exp_fetch.push_back((r - 1 + ro) * W + c + 1);
                    end
                end
                exp_wr.push_back(r * W + c);
            end
        end
    endtask

    task automatic mon();
        int ea;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_ni) begin
                if (gray_req || lbp_valid) begin
                    check_eq("req_and_valid", 128'(gray_req & lbp_valid), 0);
                end
                if (gray_req) begin
                    if (exp_fetch.size() == 0) begin
                        check_eq("fetch_extra", exp_fetch.size(), 1);
                    end else begin
                        ea = exp_fetch.pop_front();
                        check_eq("fetch_addr", gray_addr, ea);
                    end
                end
                if (win_start) begin
                    ws_cyc = cyc;
                    if (exp_wr.size() == 0) check_eq("win_extra", exp_wr.size(), 1);
                    else check_eq("win_data", win_data, exp_win(exp_wr[0]));
                end
                if (lbp_valid) begin
                    if (exp_wr.size() == 0) begin
                        check_eq("wr_extra", exp_wr.size(), 1);
                    end else begin
                        ea = exp_wr.pop_front();
                        check_eq("wr_addr", lbp_addr, ea);
                        check_eq("wr_data", lbp_data, pix(ea));
                        check_eq("wr_latency", cyc - ws_cyc, core_delay + 1);
                    end
                    wr_cnt++;
                end
            end
        end
    endtask

    // LBP core model: echoes the centre pixel core_delay cycles after win_start;
    // with spur_en it also strobes a bogus code in the win_start cycle and in the
    // cycle after each write.
    task automatic core();
        logic [7:0] c;
        forever begin
            @(negedge clk);
            if (rst_ni && win_start) begin
                c = win_data[39:32];
                if (spur_en) begin
                    core_done = 1'b1;
                    core_lbp  = 8'hEE;
                end
                @(posedge clk);
                #1;
                core_done = 1'b0;
                repeat (core_delay - 1) begin
                    @(posedge clk);
                    #1;
                end
                core_done = 1'b1;
                core_lbp  = c;
                @(posedge clk);
                #1;
                core_done = 1'b0;
                core_lbp  = 8'h00;
            end else if (rst_ni && lbp_valid && spur_en) begin
                @(posedge clk);
                #1;
                core_done = 1'b1;
                core_lbp  = 8'hEE;
                @(posedge clk);
                #1;
                core_done = 1'b0;
            end
        end
    endtask

    task automatic wait_wr(int addr, int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (lbp_valid && int'(lbp_addr) == addr) found = 1'b1;
        end
        check_eq($sformatf("wait_wr_%0d", addr), 128'(found), 1);
    endtask

    initial begin
        int  n;
        bit  found;
        rst_ni     = 1'b0;
        gray_ready = 1'b0;
        core_done  = 1'b0;
        core_lbp   = 8'h00;
        core_delay = 1;
        spur_en    = 1'b0;
        fork
            mon();
            core();
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("reset_outs", {gray_req, gray_addr, win_start, win_data, lbp_valid,
                                lbp_addr, lbp_data, finish}, 0);

        // Idle holds while gray memory is not ready
        @(posedge clk);
        #1;
        push_scan();
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("idle_no_req", {gray_req, lbp_valid, finish}, 0);
        end

        // First window and first write latency
        @(posedge clk);
        #1;
        gray_ready = 1'b1;
        n     = 0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (lbp_valid) found = 1'b1;
            else n++;
        end
        check_eq("first_wr_seen", 128'(found), 1);
        check_eq("first_wr_addr", lbp_addr, 129);
        check_eq("first_wr_le13", 128'(n <= 13), 1);

        // Row end, then stall the refill for three cycles
        wait_wr(W - 2 + W, 2000);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        gray_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("stall_no_req", 128'(gray_req), 0);
            check_eq("stall_addr_hold", gray_addr, exp_fetch[0]);
            @(posedge clk);
            #1;
        end
        gray_ready = 1'b1;

        // Slow core with spurious strobes
        wait_wr(258, 200);
        @(posedge clk);
        #1;
        core_delay = 5;
        spur_en    = 1'b1;

        // Reset while the write for centre 300 is pending
        wait_wr(299, 2000);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (win_start) found = 1'b1;
        end
        check_eq("ws_300_seen", 128'(found), 1);
        @(posedge clk);
        #1;
        rst_ni = 1'b0;
        #1;
        check_eq("reset_async", {gray_req, gray_addr, win_start, win_data, lbp_valid,
                                 lbp_addr, lbp_data, finish}, 0);
        exp_fetch.delete();
        exp_wr.delete();
        core_delay = 1;
        spur_en    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        wr_cnt = 0;
        push_scan();
        rst_ni = 1'b1;

        // Restart from the first centre and run to completion
        wait_wr(129, 40);
        wait_wr(LAST, 6000);
        @(negedge clk);
        check_eq("finish_after_last", 128'(finish), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("done_hold", {finish, gray_req, lbp_valid}, 3'b100);
        end
        check_eq("write_count", wr_cnt, NWR);
        check_eq("wr_queue_empty", exp_wr.size(), 0);
        check_eq("fetch_queue_empty", exp_fetch.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
